// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops words from a TX FIFO and serializes them: start, WIDTH data bits LSB first, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WIDTH        = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             stop_idx, stop_idx_d;
  logic [WIDTH-1:0] shift_reg, shift_d;
  logic             tx_d, rd_en_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity, parity_d;
`endif

  logic wrap;
  logic start_frame;

  assign wrap        = (cnt == CNT_MAX);
  assign start_frame = (state == S_IDLE) && tx_en && !fifo_empty;

  // State and datapath registers; every output pin comes straight from a flop.
  // NOTE: sequential state uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      stop_idx   <= stop_idx_d;
      shift_reg  <= shift_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      tx_done    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity     <= parity_d;
`endif
    end
  end

  // Next-state and datapath update.
  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = wrap ? '0 : cnt + 1'b1;
    idx_d      = idx;
    stop_idx_d = stop_idx;
    shift_d    = shift_reg;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity;
`endif
    unique case (state)
      S_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        if (start_frame) begin
          state_d = S_START;
          shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_reg >> 1;
            idx_d   = idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (wrap) begin
          if (stop_idx == STOP_LAST) state_d = S_IDLE;
          else                       stop_idx_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    tx_d    = tx;
    rd_en_d = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_frame) begin
          tx_d    = 1'b0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (wrap) tx_d = shift_reg[0];
      end
      S_DATA: begin
        if (wrap) begin
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d = parity;
`else
            tx_d = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (wrap) tx_d = 1'b1;
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (wrap && stop_idx == STOP_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx with CLKS_PER_BIT=4: table of frames sent back to back plus hand sequences for reset and tx_en gating.
module tb_uart_fifo_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PB  = 1;
`else
  localparam int SB  = 1;
  localparam int PB  = 0;
`endif
  localparam int NBITS = 1 + 8 + PB + SB;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int n_checks = 0;
  int n_err    = 0;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8), .STOP_BITS(SB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] data;
    logic       par;   // even parity of data, worked out by hand
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present one word, wait for the pop, then follow the whole frame cycle by cycle.
  // After the pop the FIFO head becomes nxt_data/nxt_empty; drop_at>=0 clears tx_en at that frame cycle.
  task automatic run_frame(input logic [7:0] data, input logic par,
                           input logic nxt_empty, input logic [7:0] nxt_data,
                           input int drop_at);
    int         waited;
    int         rd_pulses;
    logic       busy_bad, done_bad;
    logic       got;
    logic [11:0] bits;
    string      tag;
    tag = $sformatf("frame_%02h", data);
    fifo_data  = data;
    fifo_empty = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!fifo_rd_en && waited < 20);
    check({tag, "_start_latency"}, waited, 1);
    if (!fifo_rd_en) return;
    fifo_empty = nxt_empty;
    fifo_data  = nxt_data;

    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (PB == 1) bits[9] = par;

    rd_pulses = 0;
    busy_bad  = 1'b0;
    done_bad  = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      got = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (fifo_rd_en) rd_pulses++;
        if (tx !== bits[b]) got = tx;
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (tx_done !== 1'b0) done_bad = 1'b1;
        if (b * CPB + c == drop_at) tx_en = 1'b0;
        step();
      end
      check($sformatf("%s_bit%0d", tag, b), got, bits[b]);
    end
    check({tag, "_rd_pulses"}, rd_pulses, 1);
    check({tag, "_busy_held"}, busy_bad, 0);
    check({tag, "_early_done"}, done_bad, 0);
    check({tag, "_tx_done"}, tx_done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tx_end"}, tx, 1);
  endtask

  // Hold for n cycles and confirm the transmitter stays idle with no pop.
  task automatic expect_idle(input string name, input int n);
    int pops, lows, busies;
    pops = 0; lows = 0; busies = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (fifo_rd_en !== 1'b0) pops++;
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    check({name, "_pops"}, pops, 0);
    check({name, "_tx_low"}, lows, 0);
    check({name, "_busy"}, busies, 0);
  endtask

  initial begin
    int waited;
    tbl[0] = '{data: 8'h55, par: 1'b0};
    tbl[1] = '{data: 8'hA5, par: 1'b0};
    tbl[2] = '{data: 8'h07, par: 1'b1};
    tbl[3] = '{data: 8'h01, par: 1'b1};
    tbl[4] = '{data: 8'hFF, par: 1'b0};
    tbl[5] = '{data: 8'h80, par: 1'b1};
    tbl[6] = '{data: 8'h00, par: 1'b0};

    // Reset held with a non-empty FIFO and tx_en high: nothing may move.
    rst        = 1'b0;
    tx_en      = 1'b1;
    fifo_data  = 8'h55;
    fifo_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_tx_c%0d", i), tx, 1);
      check($sformatf("reset_busy_c%0d", i), busy, 0);
      check($sformatf("reset_rd_en_c%0d", i), fifo_rd_en, 0);
      check($sformatf("reset_done_c%0d", i), tx_done, 0);
    end
    fifo_empty = 1'b1;
    rst = 1'b1;
    expect_idle("post_reset", 3);

    // Table frames sent back to back: the next word is at the FIFO head right after each pop.
    for (int i = 0; i < 7; i++) begin
      if (i < 6) run_frame(tbl[i].data, tbl[i].par, 1'b0, tbl[i+1].data, -1);
      else       run_frame(tbl[i].data, tbl[i].par, 1'b1, 8'h00, -1);
    end

    // tx_en low: no frame starts even though data waits.
    tx_en      = 1'b0;
    fifo_data  = 8'h3C;
    fifo_empty = 1'b0;
    expect_idle("en_low", 10);
    // Raise tx_en, then drop it mid-frame: the frame still completes.
    tx_en = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 5);
    expect_idle("en_dropped", 10);
    tx_en = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b1, 8'h00, -1);

    // Reset during data bit 3 of 0xA5 (that bit is 0).
    fifo_data  = 8'hA5;
    fifo_empty = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!fifo_rd_en && waited < 20);
    check("midrst_pop_seen", fifo_rd_en, 1);
    fifo_empty = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check("midrst_bit3_before", tx, 0);
    rst = 1'b0;
    step();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    rst = 1'b1;
    expect_idle("midrst_after", 10);
    run_frame(8'h07, 1'b1, 1'b1, 8'h00, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- UART transmit engine that actively drains the passive TX FIFO through its full/empty interface. It is the reading end of that FIFO.
- When the FIFO is non-empty and transmission is enabled, it pops one word and serializes it onto the line. Frame format: start bit, WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits.
- Sits between the TX FIFO and the `tx` pad. All timing is derived from a per-bit clock-cycle count.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200). Must be >= 2.
- WIDTH, 8, data bits per frame. Must match the FIFO width.
- STOP_BITS, 1, number of stop bits. Legal values: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on the rising clk edge)
- tx_en  input  1  1 = allowed to start new frames; 0 = finish the current frame, then hold idle
- fifo_data  input  WIDTH  FIFO head word; valid in any cycle where fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line; idles high
- busy  output  1  1 whenever state != IDLE
- tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0; all counters and the shift register are cleared.
  - Reset mid-frame aborts immediately: tx=1 on the next cycle, no pop is issued, and the partial frame is not resumed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
- IDLE:
  - If tx_en=1 and fifo_empty=0 at an edge: latch shift_reg<=fifo_data, set fifo_rd_en<=1, tx<=0, busy<=1, go to START.
  - Otherwise hold with tx=1.
- Pop handshake:
  - fifo_rd_en is high for exactly the first cycle of START, then 0.
  - The FIFO therefore sees the pop while still non-empty. The data was captured on the same edge that raised fifo_rd_en, so the capture edge precedes the pop.
  - At most one pop per frame. Consecutive pops are at least one frame apart, which covers the FIFO's two-cycle head-update latency.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Bit counter: runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Each bit level is held for exactly CLKS_PER_BIT cycles.
- START: tx=0. On counter wrap, drive shift_reg[0], go to DATA, bit index=0.
- DATA:
  - On each wrap, shift right and drive the next bit.
  - After bit WIDTH-1 wraps: go to PARITY if the feature is compiled in, otherwise go to STOP with tx=1.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end: go to IDLE, busy<=0, and tx_done<=1 for that single IDLE cycle.
- Frame length: (1+WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames: the earliest next capture is at the edge ending the tx_done cycle. This leaves exactly 1 extra high cycle between frames.
- tx_en is sampled only in IDLE. Dropping tx_en mid-frame does not truncate the frame.
- fifo_data and fifo_empty are ignored outside IDLE. fifo_empty toggling mid-frame has no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA, lasting CLKS_PER_BIT cycles.
  - Even parity: tx = XOR of the WIDTH data bits, computed from the latched word at capture.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - No parity logic is synthesized.

Test Plan:
- Reset idle (CLKS_PER_BIT=4): hold rst=0 for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout; no pop.
- Single frame (CLKS_PER_BIT=4, no parity, fifo_data=0x55 with fifo_empty falling to 0):
  - fifo_rd_en pulses exactly 1 cycle.
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1.
  - tx_done pulses at cycle 40 after capture.
  - busy high for 40 cycles.
- Back-to-back (FIFO holds 0x01, 0xFF):
  - Two pops, two frames.
  - Exactly 4+1 high cycles between the last data bit of frame 1 and the start bit of frame 2.
  - Frame 2 data bits all 1.
- tx_en gating:
  - tx_en=0 with fifo_empty=0 -> no pop, tx=1.
  - Drop tx_en mid-frame -> frame completes normally and no new frame starts.
  - Raise tx_en again -> the next frame starts on the next edge.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0xA5 -> next cycle tx=1, busy=0; after release, no pop until fifo_empty=0 is seen in IDLE.
- Parity (UART_TX_PARITY_EN, CLKS_PER_BIT=4, STOP_BITS=2):
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - Frame length 48 cycles; tx_done at cycle 48.
